// File: rtl/riscv_hwloop_pkg.sv
// Shared types and default parameters for the RI5CY hardware-loop unit.
package riscv_hwloop_pkg;

    // Field select for a hardware-loop register write coming from ID
    typedef enum logic [1:0] {
        HWLP_START = 2'd0,
        HWLP_END   = 2'd1,
        HWLP_COUNT = 2'd2,
        HWLP_RSVD  = 2'd3
    } hwlp_wr_sel_e;

    localparam int HWLP_N_LOOPS = 2;
    localparam int HWLP_ADDR_W  = 32;
    localparam int HWLP_CNT_W   = 32;
    localparam int HWLP_WDATA_W = 32;

endpackage

// File: rtl/riscv_hwloop_slot.sv
// One hardware loop: start/end/count registers, write decode, saturating
// decrement and the per-loop match/exit/jump-candidate flags.
module riscv_hwloop_slot
    import riscv_hwloop_pkg::*;
#(
    parameter int ADDR_W = HWLP_ADDR_W,
    parameter int CNT_W  = HWLP_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  hwlp_wr_sel_e            wr_sel,
    input  logic [HWLP_WDATA_W-1:0] wr_data,
    input  logic                    dec,
    input  logic [ADDR_W-1:0]       pc,
    input  logic                    pc_valid,
    input  logic                    flush,
    output logic [ADDR_W-1:0]       start_q,
    output logic [CNT_W-1:0]        count_q,
    output logic                    active,
    output logic                    exiting,
    output logic                    jump_cand
);

    localparam int AXW = (ADDR_W > HWLP_WDATA_W) ? ADDR_W : HWLP_WDATA_W;
    localparam int CXW = (CNT_W  > HWLP_WDATA_W) ? CNT_W  : HWLP_WDATA_W;

    logic [ADDR_W-1:0] end_q;
    logic [AXW-1:0]    wr_addr_ext;
    logic [CXW-1:0]    wr_cnt_ext;
    logic              match;

    // Zero-extend the write data first, then keep the low bits, so both
    // narrower and wider address/count widths come out right.
    assign wr_addr_ext = AXW'(wr_data);
    assign wr_cnt_ext  = CXW'(wr_data);

    // A loop only matches while it still has iterations left
    assign active    = (count_q != '0);
    assign match     = pc_valid && !flush && active && (pc == end_q);
    assign exiting   = match && (count_q == CNT_W'(1));
    assign jump_cand = match && (count_q > CNT_W'(1));

    // Register update: a COUNT write beats a same-cycle decrement, while
    // START/END writes land alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
            end_q   <= '0;
            count_q <= '0;
        end else begin
            if (wr_en && wr_sel == HWLP_START) begin
                start_q <= wr_addr_ext[ADDR_W-1:0];
            end
            if (wr_en && wr_sel == HWLP_END) begin
                end_q <= wr_addr_ext[ADDR_W-1:0];
            end
            if (wr_en && wr_sel == HWLP_COUNT) begin
                count_q <= wr_cnt_ext[CNT_W-1:0];
            end else if (dec && count_q != '0) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/riscv_hwloop_unit.sv
// Hardware-loop unit: N_LOOPS slots, innermost-first priority scan that
// resolves nested loops sharing an end address, and the IF-side jump mux.
module riscv_hwloop_unit
    import riscv_hwloop_pkg::*;
#(
    parameter int N_LOOPS = HWLP_N_LOOPS,
    parameter int ADDR_W  = HWLP_ADDR_W,
    parameter int CNT_W   = HWLP_CNT_W,
    localparam int IDX_W  = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        pc_i,
    input  logic                     pc_valid_i,
    input  logic                     pc_ready_i,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [IDX_W-1:0]         wr_idx_i,
    input  logic [1:0]               wr_sel_i,
    input  logic [HWLP_WDATA_W-1:0]  wr_data_i,
    output logic                     jump_o,
    output logic [ADDR_W-1:0]        targ_addr_o,
    output logic [N_LOOPS-1:0]       dec_o,
    output logic [N_LOOPS-1:0]       active_o,
    output logic [N_LOOPS*CNT_W-1:0] count_o
);

    logic [ADDR_W-1:0]  start_arr [N_LOOPS];
    logic [N_LOOPS-1:0] exiting;
    logic [N_LOOPS-1:0] jump_cand;
    logic [N_LOOPS-1:0] dec_mask;
    hwlp_wr_sel_e       wr_sel;

    assign wr_sel = hwlp_wr_sel_e'(wr_sel_i);

    for (genvar g = 0; g < N_LOOPS; g++) begin : g_slot
        riscv_hwloop_slot #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_en_i && (wr_idx_i == IDX_W'(g))),
            .wr_sel    (wr_sel),
            .wr_data   (wr_data_i),
            .dec       (dec_o[g]),
            .pc        (pc_i),
            .pc_valid  (pc_valid_i),
            .flush     (flush_i),
            .start_q   (start_arr[g]),
            .count_q   (count_o[g*CNT_W +: CNT_W]),
            .active    (active_o[g]),
            .exiting   (exiting[g]),
            .jump_cand (jump_cand[g])
        );
    end

    // Priority scan: exiting loops retire and fall through, the first loop
    // that still iterates takes the jump and shields the outer loops.
    always_comb begin
        logic stop;
        stop        = 1'b0;
        jump_o      = 1'b0;
        targ_addr_o = '0;
        dec_mask    = '0;
        for (int i = 0; i < N_LOOPS; i++) begin
            if (!stop) begin
                if (exiting[i]) begin
                    dec_mask[i] = 1'b1;
                end else if (jump_cand[i]) begin
                    jump_o      = 1'b1;
                    targ_addr_o = start_arr[i];
                    dec_mask[i] = 1'b1;
                    stop        = 1'b1;
                end
            end
        end
    end

    // Iterations only retire when fetch actually takes the PC
    assign dec_o = dec_mask & {N_LOOPS{pc_ready_i}};

endmodule

// File: doc/riscv_hwloop_unit.md
# riscv_hwloop_unit

Parametrised hardware-loop unit for the RI5CY core: owns the start/end/count register set for `N_LOOPS` loops and compares each fetched PC against all end addresses. It issues a jump to the matching start address and retires loop iterations on the cycle fetch accepts the PC. Nested loops sharing an end address are resolved in one cycle. It sits between the ID stage (register writes) and the IF stage (PC, jump target).

## Interface
- `N_LOOPS`, 2: number of loops; index 0 is the innermost and has the highest priority.
- `ADDR_W`, 32: PC and address width.
- `CNT_W`, 32: loop counter width.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `pc_i`  in  ADDR_W  PC currently presented by fetch.
- `pc_valid_i`  in  1  `pc_i` is valid.
- `pc_ready_i`  in  1  fetch accepts `pc_i` this cycle; state commits only when `pc_valid_i && pc_ready_i`.
- `flush_i`  in  1  pipeline flush; suppresses jump and commit this cycle.
- `wr_en_i`  in  1  register write strobe from ID.
- `wr_idx_i`  in  $clog2(N_LOOPS) (min 1)  loop index to write.
- `wr_sel_i`  in  2  field select: START=0, END=1, COUNT=2, RSVD=3 (write ignored).
- `wr_data_i`  in  32  write data; zero-extended or truncated to ADDR_W/CNT_W.
- `jump_o`  out  1  take hardware-loop branch this cycle.
- `targ_addr_o`  out  ADDR_W  jump target; 0 when `jump_o`=0.
- `dec_o`  out  N_LOOPS  one-hot-or-more mask of loops decremented on this commit.
- `active_o`  out  N_LOOPS  per-loop count != 0.
- `count_o`  out  N_LOOPS×CNT_W  current count registers (CSR read path).

## Operation
- State per loop: `start_q`, `end_q`, `count_q`. A loop is active iff `count_q` != 0.
- Loop i matches when `pc_valid_i && !flush_i && active[i] && pc_i == end_q[i]`.
- Loops are scanned in index order 0..N_LOOPS-1:
  - A matching loop with `count_q` == 1 is exiting: mark `dec[i]`, no jump, continue the scan.
  - The first matching loop with `count_q` ≥ 2 is jumping: `jump_o`=1, `targ_addr_o`=`start_q[i]`, mark `dec[i]`, stop the scan.
  - Loops after the jumping loop are untouched.
- `dec_o` is the marked mask, gated by `pc_ready_i`. `jump_o` and `targ_addr_o` do not depend on `pc_ready_i`.
- Commit (`pc_valid_i && pc_ready_i && !flush_i`): every loop in `dec_o` gets `count_q` -= 1. A counter never wraps below 0.
- Writes (`wr_en_i`) update the selected field at the edge.
- Write/decrement collision on the same loop's COUNT: the write wins and the decrement is dropped.
- A write to START or END of a loop that is also decrementing takes effect together with the decrement.
- A write with `wr_idx_i` ≥ N_LOOPS is ignored.

## Timing
- Jump path is combinational from `pc_i` and registers to `jump_o`/`targ_addr_o`/`dec_o`; zero cycles.
- A register write is visible to matching on the cycle after `wr_en_i`.
- A committed decrement is visible on the next cycle. A stalled PC (`pc_ready_i`=0) re-evaluates identically each cycle with no state change.
- Reset: all `start_q`/`end_q`/`count_q` = 0. Therefore `jump_o`=0, `targ_addr_o`=0, `dec_o`=0, `active_o`=0, `count_o`=0.
- Reset mid-loop abandons all loops. Reset dominates writes and commits in the same cycle.
- `flush_i` during a stall: no jump and no decrement; fetch re-presents the PC later.

## Structure
- Package `riscv_hwloop_pkg`: `hwlp_wr_sel_e` (START/END/COUNT/RSVD) and the default parameter constants.
- Sub-module `riscv_hwloop_slot`: one loop's registers, write decode, saturating decrement, and the match/exit/jump-candidate flags.
- Top level: instantiate N_LOOPS slots, run the priority scan, drive the output mux.

## Test plan
- Basic loop: write loop0 start=0x100, end=0x10C, count=3; present 0x10C with ready twice, then once more.
  - Required: jump to 0x100 twice, counts 3→2→1.
  - Third pass: no jump, count→0, `active_o[0]`=0.
- Nested shared end: loop0 (count 1) and loop1 (count 5), both end=0x200; present 0x200 with ready.
  - Required: `jump_o`=1, target=`start_q[1]`, `dec_o`=2'b11, counts become 0 and 4.
- Stall: jump condition held with `pc_ready_i`=0 for 4 cycles, then ready.
  - Required: `jump_o`=1 every cycle, `dec_o`=0 until ready, exactly one decrement.
- Collision: write COUNT=7 to loop0 in the same cycle loop0 commits a decrement from 2.
  - Required: count=7 next cycle.
- Flush and reset: `flush_i` while at end address → `jump_o`=0 and no decrement. Assert `rst` mid-loop with a concurrent write → all outputs 0 the next cycle.
